shop_checkout: RTL
==================

// Module: shop_checkout
// PURPOSE
//  Payment side of the shop register. Latches the amount due from the billing
//  total, accepts inserted coins, and once paid >= due, dispenses change one
//  coin per handshake using greedy largest-first denominations. Cancel refunds
//  everything paid so far through the same dispense path.
// PARAMETERS
//  D0  50  largest change denomination
//  D1  10  second denomination
//  D2  5   third denomination
//  D3  1   smallest denomination; must stay 1 so any remainder can be paid out
// PORTS
//  clk        in   1   clock, rising edge
//  reset      in   1   asynchronous, active-high
//  start      in   1   1-cycle pulse: latch due, enter COLLECT
//  due        in   16  amount owed, sampled only with start in IDLE
//  coin_valid in   1   1-cycle pulse: coin inserted
//  coin_val   in   8   value of the inserted coin
//  cancel     in   1   abort the purchase and refund paid
//  chg_valid  out  1   change coin available
//  chg_denom  out  8   value of the offered change coin
//  chg_ready  in   1   dispenser accepts the coin
//  paid       out  16  running total inserted
//  busy       out  1   state != IDLE
//  done       out  1   1-cycle pulse when the transaction completes
//  coin_rej   out  1   1-cycle pulse when a coin is not accepted
// BEHAVIOUR
//  Reset (any time, including mid-dispense):
//   state=IDLE; paid=0; remain=0; chg_valid=0; chg_denom=0; done=0; coin_rej=0.
//  States: IDLE, COLLECT, DISPENSE, FINISH. All are registered.
//  IDLE:
//   start=1 -> due_r<=due, paid<=0.
//   If due==0, go to FINISH. Otherwise go to COLLECT.
//   A coin in IDLE -> coin_rej pulse next cycle; paid is unchanged.
//  COLLECT:
//   coin_valid -> paid<=sat16(paid+coin_val), saturating at 16'hFFFF.
//   The paid >= due_r check uses the updated paid value.
//   If it passes, next state is DISPENSE with remain<=paid_new-due_r.
//   If remain would be 0, go to FINISH instead.
//   cancel=1 -> remain<=paid and go to DISPENSE, or FINISH if paid==0.
//   cancel takes priority over a coin in the same cycle; that coin is rejected.
//  DISPENSE:
//   chg_valid=1 and chg_denom = largest Dk <= remain, computed from registered remain.
//   Transfer happens on chg_valid & chg_ready -> remain<=remain-chg_denom.
//   chg_denom must stay stable while chg_valid & !chg_ready.
//   After the last transfer (remain reaches 0): chg_valid<=0, go to FINISH.
//   Coins in DISPENSE -> coin_rej; cancel is ignored.
//  FINISH:
//   done=1 for exactly one cycle, then IDLE.
//   paid holds its value until the next start.
//  start outside IDLE is ignored with no effect.
//  Latency:
//   coin that completes payment -> chg_valid rises on the 2nd edge (one cycle in DISPENSE).
//   Each change coin takes at least 1 cycle; with chg_ready tied high, 1 coin per cycle.
//  Arithmetic: all arithmetic unsigned; remain is 16 bits; no negative values are possible.
// TESTING
//  1 start due=37; coins 20,20 -> paid=40; remain=3; denoms 1,1,1; done pulses.
//  2 start due=12; coin 100 -> denoms 50,10,10,10,5,1,1,1 (sum 88); chg_ready
//    toggled 1/0 -> chg_denom held stable while ready=0.
//  3 start due=30; coin 10; cancel together with coin 5 -> coin_rej; refund 10.
//  4 start due=0 -> FINISH next cycle; done=1; chg_valid never rises.
//  5 reset asserted during DISPENSE, remain=40 -> all outputs 0, IDLE; coin -> coin_rej.
//  6 paid=16'hFFF0 plus coin 255 -> paid saturates at 16'hFFFF; start while busy is ignored.

Source files
------------

// File: rtl/shop_if.sv
// Register payment-side bus: purchase control, coin intake, change handshake.
interface shop_if;
    logic        start;
    logic [15:0] due;
    logic        coin_valid;
    logic [7:0]  coin_val;
    logic        cancel;
    logic        chg_valid;
    logic [7:0]  chg_denom;
    logic        chg_ready;
    logic [15:0] paid;
    logic        busy;
    logic        done;
    logic        coin_rej;

    modport master (
        output start, due, coin_valid, coin_val, cancel, chg_ready,
        input  chg_valid, chg_denom, paid, busy, done, coin_rej
    );

    modport slave (
        input  start, due, coin_valid, coin_val, cancel, chg_ready,
        output chg_valid, chg_denom, paid, busy, done, coin_rej
    );
endinterface

// File: rtl/shop_checkout.sv
// Checkout payment unit: collects coins against a latched amount due and
// pays change (or a cancel refund) one greedy coin per handshake.
module shop_checkout #(
    parameter logic [7:0] D0 = 8'd50,
    parameter logic [7:0] D1 = 8'd10,
    parameter logic [7:0] D2 = 8'd5,
    parameter logic [7:0] D3 = 8'd1
) (
    input  logic  clk,
    input  logic  reset,
    shop_if.slave bus
);
    typedef enum logic [1:0] {IDLE, COLLECT, DISPENSE, FINISH} state_t;

    state_t      state, state_n;
    logic [15:0] due_r, due_n;
    logic [15:0] paid_r, paid_n;
    logic [15:0] remain, remain_n;
    logic [15:0] left;
    logic [16:0] sum;
    logic [7:0]  denom_r, denom_n;
    logic        chg_valid_r, chg_valid_n;
    logic        coin_rej_r, coin_rej_n;

    function automatic logic [7:0] pick(input logic [15:0] r);
        logic [7:0] d;
        if (r >= {8'd0, D0})      d = D0;
        else if (r >= {8'd0, D1}) d = D1;
        else if (r >= {8'd0, D2}) d = D2;
        else                      d = D3;
        return d;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            due_r       <= '0;
            paid_r      <= '0;
            remain      <= '0;
            denom_r     <= '0;
            chg_valid_r <= 1'b0;
            coin_rej_r  <= 1'b0;
        end else begin
            state       <= state_n;
            due_r       <= due_n;
            paid_r      <= paid_n;
            remain      <= remain_n;
            denom_r     <= denom_n;
            chg_valid_r <= chg_valid_n;
            coin_rej_r  <= coin_rej_n;
        end
    end

    always_comb begin
        state_n     = state;
        due_n       = due_r;
        paid_n      = paid_r;
        remain_n    = remain;
        denom_n     = denom_r;
        chg_valid_n = chg_valid_r;
        coin_rej_n  = 1'b0;
        sum         = {1'b0, paid_r} + {9'd0, bus.coin_val};
        left        = remain - {8'd0, denom_r};
        case (state)
            IDLE: begin
                coin_rej_n = bus.coin_valid;
                if (bus.start) begin
                    due_n   = bus.due;
                    paid_n  = '0;
                    state_n = (bus.due == 16'd0) ? FINISH : COLLECT;
                end
            end
            COLLECT: begin
                if (bus.cancel) begin
                    coin_rej_n = bus.coin_valid;
                    remain_n   = paid_r;
                    state_n    = (paid_r == 16'd0) ? FINISH : DISPENSE;
                end else if (bus.coin_valid) begin
                    paid_n = sum[16] ? 16'hFFFF : sum[15:0];
                    if (paid_n >= due_r) begin
                        remain_n = paid_n - due_r;
                        state_n  = (paid_n == due_r) ? FINISH : DISPENSE;
                    end
                end
            end
            DISPENSE: begin
                coin_rej_n = bus.coin_valid;
                // First cycle only arms the offer from the registered remainder
                if (!chg_valid_r) begin
                    if (remain == 16'd0) begin
                        state_n = FINISH;
                    end else begin
                        chg_valid_n = 1'b1;
                        denom_n     = pick(remain);
                    end
                end else if (bus.chg_ready) begin
                    remain_n = left;
                    if (left == 16'd0) begin
                        chg_valid_n = 1'b0;
                        denom_n     = '0;
                        state_n     = FINISH;
                    end else begin
                        denom_n = pick(left);
                    end
                end
            end
            FINISH: begin
                coin_rej_n = bus.coin_valid;
                state_n    = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.chg_valid = chg_valid_r;
    assign bus.chg_denom = denom_r;
    assign bus.paid      = paid_r;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == FINISH);
    assign bus.coin_rej  = coin_rej_r;
endmodule
